// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VGA  = 2'd1,
        CPU  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_VGA = 1'b1
    } owner_t;

    localparam int unsigned STARVE_W = 8;

endpackage

// File: rtl/arb_starve_timer.sv
// Saturating count of consecutive denied CPU cycles; o_sat forces a CPU win.
module arb_starve_timer
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX_WAIT);

    logic [STARVE_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX_CNT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sat = (r_cnt == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data memory arbiter: VGA priority, CPU starvation guarantee, 1-cycle read return.
// Define MEM_ARB_PERF_EN to add the perf_cpu_stall / perf_vga_grants counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic          vga_gnt,
    output logic          vga_rvalid,
    output logic [DW-1:0] vga_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]   perf_cpu_stall,
    output logic [31:0]   perf_vga_grants,
`endif
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    owner_t     r_rd_owner;
    logic       r_rd_pend;
    logic       w_cpu_gnt;
    logic       w_vga_gnt;
    logic       w_sat;
    logic       w_force;

    assign w_force = cpu_req & w_sat;

    arb_starve_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk   (clk),
        .rst_n (reset),
        .i_inc (cpu_req & ~w_cpu_gnt),
        .i_clr (w_cpu_gnt | ~cpu_req),
        .o_sat (w_sat)
    );

    always_comb begin
        w_cpu_gnt   = 1'b0;
        w_vga_gnt   = 1'b0;
        w_state_nxt = IDLE;
        if (w_force) begin
            w_cpu_gnt = 1'b1;
        end else if (vga_req) begin
            w_vga_gnt = 1'b1;
        end else if (cpu_req) begin
            w_cpu_gnt = 1'b1;
        end
        case (r_state)
            IDLE, VGA, CPU: w_state_nxt = w_cpu_gnt ? CPU : (w_vga_gnt ? VGA : IDLE);
            default:        w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= OWN_CPU;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_pend  <= w_vga_gnt | (w_cpu_gnt & ~cpu_we);
            r_rd_owner <= w_vga_gnt ? OWN_VGA : OWN_CPU;
        end
    end

    // Grants are combinational from requests, so mask them while reset is held.
    assign cpu_gnt = w_cpu_gnt & reset;
    assign vga_gnt = w_vga_gnt & reset;

    assign mem_en    = cpu_gnt | vga_gnt;
    assign mem_we    = cpu_gnt & cpu_we;
    assign mem_addr  = cpu_gnt ? cpu_addr : (vga_gnt ? vga_addr : '0);
    assign mem_wdata = cpu_gnt ? cpu_wdata : '0;

    assign cpu_rvalid = r_rd_pend & (r_rd_owner == OWN_CPU);
    assign vga_rvalid = r_rd_pend & (r_rd_owner == OWN_VGA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign vga_rdata  = vga_rvalid ? mem_rdata : '0;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_cpu_stall;
    logic [31:0] r_perf_vga_grants;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_cpu_stall  <= '0;
            r_perf_vga_grants <= '0;
        end else begin
            if (cpu_req && !w_cpu_gnt) r_perf_cpu_stall  <= r_perf_cpu_stall + 32'd1;
            if (w_vga_gnt)             r_perf_vga_grants <= r_perf_vga_grants + 32'd1;
        end
    end

    assign perf_cpu_stall  = r_perf_cpu_stall;
    assign perf_vga_grants = r_perf_vga_grants;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned MAXW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        vga_req = 1'b0;
    logic [31:0] vga_addr = '0;
    logic        vga_gnt, vga_rvalid;
    logic [31:0] vga_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_cpu_stall, perf_vga_grants;
`endif

    mem_port_arbiter #(
        .AW       (32),
        .DW       (32),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .vga_req    (vga_req),
        .vga_addr   (vga_addr),
        .vga_gnt    (vga_gnt),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
`ifdef MEM_ARB_PERF_EN
        .perf_cpu_stall  (perf_cpu_stall),
        .perf_vga_grants (perf_vga_grants),
`endif
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i == 16) ? 32'hDEADBEEF : (32'hA500_0000 ^ (i * 32'h0001_0203));
    endfunction

    // Synchronous single-port RAM seen by the arbiter (64 words).
    logic [31:0] ram [64];
    logic        written [64];
    logic        ram_clr = 1'b1;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) written[i] <= 1'b0;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[7:2]]     <= mem_wdata;
                written[mem_addr[7:2]] <= 1'b1;
            end else begin
                mem_rdata <= written[mem_addr[7:2]] ? ram[mem_addr[7:2]] : init_word(32'(mem_addr[7:2]));
            end
        end
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: transaction level, no knowledge of the RTL encoding.
    logic [31:0] ref_mem [64];
    int unsigned wait_cnt = 0;
    bit          pend_v = 0, pend_cpu = 0;
    logic [31:0] pend_d = '0;
    bit          last_cpu_gnt = 0;
    int unsigned m_stall = 0, m_vgrants = 0;

    // Called at a negedge with inputs driven; checks this cycle, advances the model, returns at next negedge.
    task automatic step();
        bit          frc, e_c, e_v, e_we, e_cv, e_vv;
        logic [31:0] e_addr, e_wd;
        #1;
        frc    = cpu_req && (wait_cnt == MAXW);
        e_c    = reset && (frc || (cpu_req && !vga_req));
        e_v    = reset && !e_c && vga_req;
        e_we   = e_c && cpu_we;
        e_addr = e_c ? cpu_addr : (e_v ? vga_addr : 32'h0);
        e_wd   = e_c ? cpu_wdata : 32'h0;
        e_cv   = reset && pend_v && pend_cpu;
        e_vv   = reset && pend_v && !pend_cpu;
        check_eq("gnt", {cpu_gnt, vga_gnt}, {e_c, e_v});
        check_eq("mem_en_we", {mem_en, mem_we}, {e_c | e_v, e_we});
        check_eq("mem_addr", mem_addr, e_addr);
        check_eq("mem_wdata", mem_wdata, e_wd);
        check_eq("cpu_rvalid", cpu_rvalid, e_cv);
        check_eq("cpu_rdata", cpu_rdata, e_cv ? pend_d : 32'h0);
        check_eq("vga_rvalid", vga_rvalid, e_vv);
        check_eq("vga_rdata", vga_rdata, e_vv ? pend_d : 32'h0);
`ifdef MEM_ARB_PERF_EN
        check_eq("perf_cpu_stall", perf_cpu_stall, m_stall);
        check_eq("perf_vga_grants", perf_vga_grants, m_vgrants);
`endif
        @(posedge clk);
        if (!reset) begin
            wait_cnt = 0; pend_v = 0; pend_cpu = 0; m_stall = 0; m_vgrants = 0;
        end else begin
            if (cpu_req && !e_c) m_stall++;
            if (e_v) m_vgrants++;
            pend_v   = e_v || (e_c && !cpu_we);
            pend_cpu = e_c;
            pend_d   = ref_mem[e_c ? cpu_addr[7:2] : vga_addr[7:2]];
            if (e_we) ref_mem[cpu_addr[7:2]] = cpu_wdata;
            if (cpu_req && !e_c) wait_cnt = (wait_cnt < MAXW) ? wait_cnt + 1 : wait_cnt;
            else                 wait_cnt = 0;
        end
        last_cpu_gnt = e_c;
        @(negedge clk);
    endtask

    int unsigned gnt_at;
    int unsigned dens;

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        // Reset state, with both requesters asserting to show grants stay masked.
        @(negedge clk);
        cpu_req = 1'b1; vga_req = 1'b1; cpu_addr = 32'h40; vga_addr = 32'h80;
        step();
        check_eq("rst_mem_en", mem_en, 1'b0);
        step();
        ram_clr = 1'b0;
        cpu_req = 1'b0; vga_req = 1'b0;
        reset = 1'b1;
        step();

        // CPU read alone: same-cycle grant, data one cycle later.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        #1 check_eq("t1_cpu_gnt", cpu_gnt, 1'b1);
        step();
        cpu_req = 1'b0;
        #1 check_eq("t1_rvalid", cpu_rvalid, 1'b1);
        check_eq("t1_rdata", cpu_rdata, 32'hDEADBEEF);
        step();

        // Collision then starvation: CPU write forced through on the 9th cycle.
        vga_req = 1'b1; vga_addr = 32'hC0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h84; cpu_wdata = 32'h1234_5678;
        gnt_at = 0;
        for (int n = 1; n <= 20 && gnt_at == 0; n++) begin
            #1;
            if (n == 1) begin
                check_eq("t2_vga_gnt", {vga_gnt, cpu_gnt}, 2'b10);
                check_eq("t2_mem_addr", mem_addr, 32'hC0);
                check_eq("t2_mem_we", mem_we, 1'b0);
            end
            if (cpu_gnt) begin
                gnt_at = n;
                check_eq("t3_mem_we", mem_we, 1'b1);
            end
            step();
            if (gnt_at != 0) cpu_req = 1'b0;
        end
        check_eq("t3_gnt_cycle", gnt_at, MAXW + 1);
        #1 check_eq("t3_vga_resume", vga_gnt, 1'b1);
        step();

        // Reset mid-read: pending VGA data must never appear.
        vga_req = 1'b1; vga_addr = 32'h10; cpu_req = 1'b0;
        #1 check_eq("t5_vga_gnt", vga_gnt, 1'b1);
        step();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0;
        #1 check_eq("t5_rvalid_dropped", vga_rvalid, 1'b0);
        step();
        step();
        reset = 1'b1;
        cpu_req = 1'b0; vga_req = 1'b0;
        #1 check_eq("t5_no_stale", {vga_rvalid, cpu_rvalid}, 2'b00);
        step();

        // Randomized traffic: light then heavy VGA load to exercise forced CPU wins.
        for (int i = 0; i < 3000; i++) begin
            dens = (i < 1500) ? 60 : 95;
            if (last_cpu_gnt || !cpu_req) begin
                cpu_req   = ($urandom_range(0, 2) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                cpu_wdata = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                cpu_req = 1'b0;
            end
            vga_req  = ($urandom_range(0, 99) < dens);
            vga_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            step();
        end

        cpu_req = 1'b0; vga_req = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
